sad_job_ctrl: RTL and testbench

//  Job sequencer and port arbiter for the SAD engine. Host preloads operand SRAMs A/B, issues Start, then reads

---
 rtl/sad_job_ctrl_pkg.sv | 24 ++
 rtl/sad_job_ctrl_port_mux.sv | 66 ++++++
 rtl/sad_job_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_sad_job_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_job_ctrl_pkg.sv
// Shared SAD controller definitions: default widths, write level, watchdog
// limit and the job FSM state encoding.
package sad_job_ctrl_pkg;

  localparam int   A_WIDTH_DEF  = 15;
  localparam int   D_WIDTH_DEF  = 8;
  localparam int   C_WIDTH_DEF  = 7;
  localparam int   R_WIDTH_DEF  = 32;
  localparam logic WR_LEVEL_DEF = 1'b1;
  localparam int   WDOG_MAX_DEF = 40000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The host owns the memory ports only while no job is in flight.
  function automatic logic host_owns(input state_t st);
    return (st == ST_IDLE);
  endfunction

endpackage

// File: rtl/sad_job_ctrl_port_mux.sv
// Combinational owner select for the operand (A/B) and result (C) memory
// ports: host side while idle, SAD core side while a job is in flight.
module sad_job_ctrl_port_mux
  import sad_job_ctrl_pkg::*;
#(
  parameter int   A_WIDTH  = A_WIDTH_DEF,
  parameter int   D_WIDTH  = D_WIDTH_DEF,
  parameter int   C_WIDTH  = C_WIDTH_DEF,
  parameter logic WR_LEVEL = WR_LEVEL_DEF
) (
  input  logic               host_sel,
  input  logic               host_wr,
  input  logic [A_WIDTH-1:0] host_addr,
  input  logic [D_WIDTH-1:0] host_da,
  input  logic [D_WIDTH-1:0] host_db,
  input  logic               host_rd,
  input  logic [C_WIDTH-1:0] host_raddr,
  input  logic [A_WIDTH-1:0] sad_a_addr,
  input  logic [A_WIDTH-1:0] sad_b_addr,
  input  logic [C_WIDTH-1:0] sad_c_addr,
  input  logic               sad_i_rw,
  input  logic               sad_i_en,
  input  logic               sad_o_rw,
  input  logic               sad_o_en,
  output logic [A_WIDTH-1:0] mem_a_addr,
  output logic [A_WIDTH-1:0] mem_b_addr,
  output logic [D_WIDTH-1:0] mem_a_di,
  output logic [D_WIDTH-1:0] mem_b_di,
  output logic               mem_i_rw,
  output logic               mem_i_en,
  output logic [C_WIDTH-1:0] mem_c_addr,
  output logic               mem_o_rw,
  output logic               mem_o_en
);

  // Route every memory port from the current owner; the core never writes A/B data.
  always_comb begin
    mem_a_addr = sad_a_addr;
    mem_b_addr = sad_b_addr;
    mem_a_di   = {D_WIDTH{1'b0}};
    mem_b_di   = {D_WIDTH{1'b0}};
    mem_i_rw   = sad_i_rw;
    mem_i_en   = sad_i_en;
    mem_c_addr = sad_c_addr;
    mem_o_rw   = sad_o_rw;
    mem_o_en   = sad_o_en;
    if (host_sel) begin
      mem_a_addr = host_addr;
      mem_b_addr = host_addr;
      mem_a_di   = host_da;
      mem_b_di   = host_db;
      mem_i_en   = host_wr;
      if (host_wr) begin
        mem_i_rw = WR_LEVEL;
      end else begin
        mem_i_rw = ~WR_LEVEL;
      end
      mem_c_addr = host_raddr;
      mem_o_en   = host_rd;
      mem_o_rw   = ~WR_LEVEL;
    end else begin
      mem_i_en = sad_i_en;
    end
  end

endmodule

// File: rtl/sad_job_ctrl.sv
// SAD job sequencer and port arbiter. The host preloads A/B, starts a job,
// and reads results from C once the core reports done.
// Optional feature macro: SAD_WDOG_EN (RUN-state watchdog with core abort).
module sad_job_ctrl
  import sad_job_ctrl_pkg::*;
#(
  parameter int   A_WIDTH  = A_WIDTH_DEF,
  parameter int   D_WIDTH  = D_WIDTH_DEF,
  parameter int   C_WIDTH  = C_WIDTH_DEF,
  parameter int   R_WIDTH  = R_WIDTH_DEF,
  parameter logic WR_LEVEL = WR_LEVEL_DEF,
  parameter int   WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Host_Start,
  input  logic               Host_Wr,
  input  logic [A_WIDTH-1:0] Host_Addr,
  input  logic [D_WIDTH-1:0] Host_DA,
  input  logic [D_WIDTH-1:0] Host_DB,
  input  logic               Host_Rd,
  input  logic [C_WIDTH-1:0] Host_RAddr,
  output logic [R_WIDTH-1:0] Host_RData,
  output logic               Host_RValid,
  output logic               Busy,
  output logic               Job_Done,
  output logic [15:0]        Job_Cnt,
  output logic               Err_Busy,
  output logic               Err_Tmo,
  output logic               Sad_Go,
  output logic               Sad_Rst,
  input  logic               Sad_Done,
  input  logic [A_WIDTH-1:0] Sad_A_Addr,
  input  logic [A_WIDTH-1:0] Sad_B_Addr,
  input  logic [C_WIDTH-1:0] Sad_C_Addr,
  input  logic               Sad_I_RW,
  input  logic               Sad_I_En,
  input  logic               Sad_O_RW,
  input  logic               Sad_O_En,
  output logic [A_WIDTH-1:0] Mem_A_Addr,
  output logic [A_WIDTH-1:0] Mem_B_Addr,
  output logic [D_WIDTH-1:0] Mem_A_Di,
  output logic [D_WIDTH-1:0] Mem_B_Di,
  output logic               Mem_I_RW,
  output logic               Mem_I_En,
  output logic [C_WIDTH-1:0] Mem_C_Addr,
  output logic               Mem_O_RW,
  output logic               Mem_O_En,
  input  logic [R_WIDTH-1:0] Mem_C_Data
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               host_sel_s;
  logic               start_acc_s;
  logic               host_req_s;
  logic               sad_go_r;
  logic               job_done_r;
  logic               busy_r;
  logic [15:0]        job_cnt_r;
  logic               err_busy_r;
  logic               rd_pend_r;
  logic [R_WIDTH-1:0] rdata_r;

  assign host_sel_s  = host_owns(state_r);
  assign start_acc_s = Host_Start & host_sel_s;
  assign host_req_s  = Host_Start | Host_Wr | Host_Rd;

`ifdef SAD_WDOG_EN
  localparam int WD_W = $clog2(WDOG_MAX + 1);
  logic [WD_W-1:0] wdog_cnt_r;
  logic            wdog_hit_s;
  logic            wdog_to_s;
  logic            sad_rst_r;
  logic            err_tmo_r;

  // Last permitted RUN cycle: the counter reads WDOG_MAX-1 during the WDOG_MAX-th RUN cycle.
  assign wdog_hit_s = (wdog_cnt_r == WD_W'(WDOG_MAX - 1));
`endif

  // Next-state decode; Sad_Done is only honoured while the core is running.
  always_comb begin
    state_nxt_s = state_r;
`ifdef SAD_WDOG_EN
    wdog_to_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (Host_Start) begin
          state_nxt_s = ST_GO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GO: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (Sad_Done) begin
          state_nxt_s = ST_DONE;
        end
`ifdef SAD_WDOG_EN
        else if (wdog_hit_s) begin
          state_nxt_s = ST_IDLE;
          wdog_to_s   = 1'b1;
        end
`endif
        else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus outputs decoded from the next state so they align with it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      sad_go_r   <= 1'b0;
      job_done_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      sad_go_r   <= (state_nxt_s == ST_GO);
      job_done_r <= (state_nxt_s == ST_DONE);
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Completed-job counter, bumped on entry to DONE and wrapping naturally.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      job_cnt_r <= 16'd0;
    end else if (state_nxt_s == ST_DONE) begin
      job_cnt_r <= job_cnt_r + 16'd1;
    end
  end

  // Sticky flag for host requests dropped while a job owns the memories.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_busy_r <= 1'b0;
    end else if (start_acc_s) begin
      err_busy_r <= 1'b0;
    end else if (!host_sel_s && host_req_s) begin
      err_busy_r <= 1'b1;
    end
  end

  // Track an accepted result read and hold the returned word after the pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_pend_r <= 1'b0;
      rdata_r   <= {R_WIDTH{1'b0}};
    end else begin
      rd_pend_r <= Host_Rd & host_sel_s;
      if (rd_pend_r) begin
        rdata_r <= Mem_C_Data;
      end
    end
  end

`ifdef SAD_WDOG_EN
  // RUN-cycle watchdog counter, restarted on every GO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else if (state_r == ST_GO) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      wdog_cnt_r <= wdog_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end
  end

  // Core abort pulse and sticky timeout flag, cleared by the next accepted start.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sad_rst_r <= 1'b0;
      err_tmo_r <= 1'b0;
    end else begin
      sad_rst_r <= wdog_to_s;
      if (start_acc_s) begin
        err_tmo_r <= 1'b0;
      end else if (wdog_to_s) begin
        err_tmo_r <= 1'b1;
      end
    end
  end

  assign Sad_Rst = sad_rst_r;
  assign Err_Tmo = err_tmo_r;
`else
  assign Sad_Rst = 1'b0;
  assign Err_Tmo = 1'b0;
`endif

  // The synchronous C read lands the cycle after the request, alongside the valid pulse.
  assign Host_RData  = rd_pend_r ? Mem_C_Data : rdata_r;
  assign Host_RValid = rd_pend_r;
  assign Busy        = busy_r;
  assign Job_Done    = job_done_r;
  assign Job_Cnt     = job_cnt_r;
  assign Err_Busy    = err_busy_r;
  assign Sad_Go      = sad_go_r;

  sad_job_ctrl_port_mux #(
    .A_WIDTH  (A_WIDTH),
    .D_WIDTH  (D_WIDTH),
    .C_WIDTH  (C_WIDTH),
    .WR_LEVEL (WR_LEVEL)
  ) u_port_mux (
    .host_sel   (host_sel_s),
    .host_wr    (Host_Wr),
    .host_addr  (Host_Addr),
    .host_da    (Host_DA),
    .host_db    (Host_DB),
    .host_rd    (Host_Rd),
    .host_raddr (Host_RAddr),
    .sad_a_addr (Sad_A_Addr),
    .sad_b_addr (Sad_B_Addr),
    .sad_c_addr (Sad_C_Addr),
    .sad_i_rw   (Sad_I_RW),
    .sad_i_en   (Sad_I_En),
    .sad_o_rw   (Sad_O_RW),
    .sad_o_en   (Sad_O_En),
    .mem_a_addr (Mem_A_Addr),
    .mem_b_addr (Mem_B_Addr),
    .mem_a_di   (Mem_A_Di),
    .mem_b_di   (Mem_B_Di),
    .mem_i_rw   (Mem_I_RW),
    .mem_i_en   (Mem_I_En),
    .mem_c_addr (Mem_C_Addr),
    .mem_o_rw   (Mem_O_RW),
    .mem_o_en   (Mem_O_En)
  );

endmodule

// File: tb/tb_sad_job_ctrl.sv
// Directed bench for sad_job_ctrl with behavioural A/B/C memories.
// Watchdog steps are compiled in when SAD_WDOG_EN is defined (limit 16).
module tb_sad_job_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Host_Start, Host_Wr, Host_Rd;
  logic [14:0] Host_Addr;
  logic [7:0]  Host_DA, Host_DB;
  logic [6:0]  Host_RAddr;
  logic [31:0] Host_RData;
  logic        Host_RValid, Busy, Job_Done, Err_Busy, Err_Tmo, Sad_Go, Sad_Rst;
  logic [15:0] Job_Cnt;
  logic        Sad_Done;
  logic [14:0] Sad_A_Addr, Sad_B_Addr;
  logic [6:0]  Sad_C_Addr;
  logic        Sad_I_RW, Sad_I_En, Sad_O_RW, Sad_O_En;
  logic [14:0] Mem_A_Addr, Mem_B_Addr;
  logic [7:0]  Mem_A_Di, Mem_B_Di;
  logic        Mem_I_RW, Mem_I_En, Mem_O_RW, Mem_O_En;
  logic [6:0]  Mem_C_Addr;
  logic [31:0] Mem_C_Data;

  logic [7:0]  mem_a [0:32767];
  logic [7:0]  mem_b [0:32767];
  logic [31:0] mem_c [0:127];

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  sad_job_ctrl #(.WDOG_MAX(16)) dut (
    .Clk(Clk), .Rst(Rst), .Host_Start(Host_Start), .Host_Wr(Host_Wr),
    .Host_Addr(Host_Addr), .Host_DA(Host_DA), .Host_DB(Host_DB),
    .Host_Rd(Host_Rd), .Host_RAddr(Host_RAddr), .Host_RData(Host_RData),
    .Host_RValid(Host_RValid), .Busy(Busy), .Job_Done(Job_Done),
    .Job_Cnt(Job_Cnt), .Err_Busy(Err_Busy), .Err_Tmo(Err_Tmo),
    .Sad_Go(Sad_Go), .Sad_Rst(Sad_Rst), .Sad_Done(Sad_Done),
    .Sad_A_Addr(Sad_A_Addr), .Sad_B_Addr(Sad_B_Addr), .Sad_C_Addr(Sad_C_Addr),
    .Sad_I_RW(Sad_I_RW), .Sad_I_En(Sad_I_En), .Sad_O_RW(Sad_O_RW), .Sad_O_En(Sad_O_En),
    .Mem_A_Addr(Mem_A_Addr), .Mem_B_Addr(Mem_B_Addr), .Mem_A_Di(Mem_A_Di),
    .Mem_B_Di(Mem_B_Di), .Mem_I_RW(Mem_I_RW), .Mem_I_En(Mem_I_En),
    .Mem_C_Addr(Mem_C_Addr), .Mem_O_RW(Mem_O_RW), .Mem_O_En(Mem_O_En),
    .Mem_C_Data(Mem_C_Data)
  );

  // Operand memories: write when enabled with the write level on RW.
  always @(posedge Clk) begin
    if (Mem_I_En && Mem_I_RW == 1'b1) begin
      mem_a[Mem_A_Addr] <= Mem_A_Di;
      mem_b[Mem_B_Addr] <= Mem_B_Di;
    end
  end

  // Result memory: one-cycle synchronous read.
  always @(posedge Clk) begin
    if (Mem_O_En && Mem_O_RW == 1'b0) begin
      Mem_C_Data <= mem_c[Mem_C_Addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem_c[i] = 32'h0;
    mem_c[3]   = 32'h0000_01F4;
    Mem_C_Data = 32'h0;
    Rst = 1'b1; Host_Start = 1'b0; Host_Wr = 1'b0; Host_Rd = 1'b0;
    Host_Addr = 15'h0; Host_DA = 8'h0; Host_DB = 8'h0; Host_RAddr = 7'h0;
    Sad_Done = 1'b0; Sad_A_Addr = 15'h0ABC; Sad_B_Addr = 15'h0123; Sad_C_Addr = 7'h55;
    Sad_I_RW = 1'b0; Sad_I_En = 1'b1; Sad_O_RW = 1'b1; Sad_O_En = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 32'd0);
    chk("rst_go", Sad_Go, 32'd0);
    chk("rst_done", Job_Done, 32'd0);
    chk("rst_rvalid", Host_RValid, 32'd0);
    chk("rst_cnt", Job_Cnt, 32'd0);
    chk("rst_errs", {Err_Busy, Err_Tmo, Sad_Rst}, 32'd0);
    chk("rst_rdata", Host_RData, 32'd0);
    Rst = 1'b0;

    // Host write A[5]=0x12, B[5]=0x34
    tick();
    Host_Wr = 1'b1; Host_Addr = 15'd5; Host_DA = 8'h12; Host_DB = 8'h34;
    #1;
    chk("wr_i_en", Mem_I_En, 32'd1);
    chk("wr_i_rw", Mem_I_RW, 32'd1);
    chk("wr_a_addr", Mem_A_Addr, 32'd5);
    chk("wr_a_di", Mem_A_Di, 32'h12);
    chk("wr_b_di", Mem_B_Di, 32'h34);
    tick();
    Host_Wr = 1'b0;
    #1;
    chk("wr_mem_a5", mem_a[5], 32'h12);
    chk("wr_mem_b5", mem_b[5], 32'h34);
    chk("idle_i_rw", Mem_I_RW, 32'd0);

    // Job aborted by Rst in RUN; Sad_Done during GO must be ignored
    Host_Start = 1'b1;
    #1;
    chk("start_busy_pre", Busy, 32'd0);
    tick();
    Host_Start = 1'b0; Sad_Done = 1'b1;
    #1;
    chk("j1_go", Sad_Go, 32'd1);
    chk("j1_go_busy", Busy, 32'd1);
    tick();
    Sad_Done = 1'b0;
    #1;
    chk("j1_run_go", Sad_Go, 32'd0);
    chk("j1_done_in_go_ignored", {Busy, Job_Done}, 32'b10);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    chk("abort_busy", Busy, 32'd0);
    chk("abort_go", Sad_Go, 32'd0);
    chk("abort_cnt", Job_Cnt, 32'd0);
    chk("abort_mem_a5", mem_a[5], 32'h12);
    Sad_Done = 1'b1; Host_Addr = 15'd7;
    #1;
    chk("abort_host_owns", Mem_A_Addr, 32'd7);
    tick();
    Sad_Done = 1'b0;
    #1;
    chk("idle_done_ignored", {Busy, Job_Done}, 32'd0);
    tick();
    chk("idle_done_cnt", Job_Cnt, 32'd0);

    // Full job: Sad_Done 10 cycles after Go, host write during RUN dropped
    Host_Start = 1'b1;
    tick();
    Host_Start = 1'b0;
    #1;
    chk("j2_go", Sad_Go, 32'd1);
    tick();
    Host_Wr = 1'b1; Host_Addr = 15'd5; Host_DA = 8'hEE; Host_DB = 8'hDD;
    #1;
    chk("run_a_addr", Mem_A_Addr, 32'h0ABC);
    chk("run_b_addr", Mem_B_Addr, 32'h0123);
    chk("run_c_addr", Mem_C_Addr, 32'h55);
    chk("run_a_di", Mem_A_Di, 32'h0);
    chk("run_ctl", {Mem_I_En, Mem_I_RW, Mem_O_En, Mem_O_RW}, 32'b1001);
    chk("run_go_low", Sad_Go, 32'd0);
    tick();
    Host_Wr = 1'b0;
    #1;
    chk("err_busy_set", Err_Busy, 32'd1);
    chk("busy_wr_dropped_a", mem_a[5], 32'h12);
    chk("busy_wr_dropped_b", mem_b[5], 32'h34);
    repeat (8) tick();
    chk("j2_still_busy", {Busy, Job_Done}, 32'b10);
    Sad_Done = 1'b1;
    tick();
    Sad_Done = 1'b0;
    #1;
    chk("j2_done_pulse", Job_Done, 32'd1);
    chk("j2_cnt", Job_Cnt, 32'd1);
    chk("j2_done_busy", Busy, 32'd1);
    tick();
    chk("j2_idle", {Busy, Job_Done}, 32'd0);
    chk("j2_cnt_hold", Job_Cnt, 32'd1);
    chk("err_busy_sticky", Err_Busy, 32'd1);

    // Result read C[3]
    Host_Rd = 1'b1; Host_RAddr = 7'd3;
    #1;
    chk("rd_o_en", {Mem_O_En, Mem_O_RW}, 32'b10);
    chk("rd_c_addr", Mem_C_Addr, 32'd3);
    chk("rd_rvalid_early", Host_RValid, 32'd0);
    tick();
    Host_Rd = 1'b0;
    #1;
    chk("rd_rvalid", Host_RValid, 32'd1);
    chk("rd_rdata", Host_RData, 32'h0000_01F4);
    tick();
    chk("rd_rvalid_end", Host_RValid, 32'd0);
    chk("rd_rdata_hold", Host_RData, 32'h0000_01F4);

    // Start together with a host write: both take effect, Err_Busy clears
    Host_Start = 1'b1; Host_Wr = 1'b1; Host_Addr = 15'd6; Host_DA = 8'h56; Host_DB = 8'h78;
    tick();
    Host_Start = 1'b0; Host_Wr = 1'b0;
    #1;
    chk("sw_mem_a6", mem_a[6], 32'h56);
    chk("sw_go", Sad_Go, 32'd1);
    chk("err_busy_cleared", Err_Busy, 32'd0);
`ifdef SAD_WDOG_EN
    repeat (16) tick();
    chk("wd_pre_busy", {Busy, Sad_Rst}, 32'b10);
    tick();
    chk("wd_rst_pulse", Sad_Rst, 32'd1);
    chk("wd_err_tmo", Err_Tmo, 32'd1);
    chk("wd_idle", {Busy, Job_Done}, 32'd0);
    chk("wd_cnt", Job_Cnt, 32'd1);
    tick();
    chk("wd_rst_end", Sad_Rst, 32'd0);
    chk("wd_tmo_sticky", Err_Tmo, 32'd1);
    Host_Start = 1'b1;
    tick();
    Host_Start = 1'b0;
    #1;
    chk("wd_tmo_cleared", Err_Tmo, 32'd0);
    tick();
    Sad_Done = 1'b1;
    tick();
    Sad_Done = 1'b0;
    #1;
    chk("wd_j4_done", {Job_Done, Job_Cnt}, {15'd0, 1'b1, 16'd2});
    tick();
    chk("wd_j4_idle", Busy, 32'd0);
`else
    repeat (60) tick();
    chk("nowd_busy", Busy, 32'd1);
    chk("nowd_flags", {Sad_Rst, Err_Tmo}, 32'd0);
    Sad_Done = 1'b1;
    tick();
    Sad_Done = 1'b0;
    #1;
    chk("nowd_done", {Job_Done, Job_Cnt}, {15'd0, 1'b1, 16'd2});
    tick();
    chk("nowd_idle", Busy, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
